// File: rtl/i2c_target_regs.sv
// I2C target responder with an 8-bit register pointer.
// SCL/SDA are synchronized, glitch-filtered and oversampled on phi0. Incoming
// bytes are written to an external register bank, and reads are served from it.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       phi0,
  input  logic       res,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK
  } state_t;

  state_t state, state_n;

  logic [1:0]          scl_sync, sda_sync;
  logic [FILT_LEN-1:0] scl_hist, sda_hist;
  logic                scl_f, sda_f, scl_q, sda_q;
  logic                scl_rise, scl_fall, start_ev, stop_ev;

  logic [3:0] cnt, cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] rx_byte;
  logic       rw, rw_n;
  logic       rd_d;
  logic       sda_oe_n, we_n, rd_n, busy_n;
  logic [7:0] addr_n, wdata_n;

  // Two-flop synchronizers feeding a run-length glitch filter; all preload high
  always_ff @(posedge phi0 or negedge res) begin
    if (!res) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= FILT_LEN'({scl_hist, scl_sync[1]});
      sda_hist <= FILT_LEN'({sda_hist, sda_sync[1]});
      if (&scl_hist)       scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist)       sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_ev = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_ev  = scl_f & scl_q & ~sda_q & sda_f;
  assign rx_byte  = {shreg[6:0], sda_f};

  // State and output registers
  always_ff @(posedge phi0 or negedge res) begin
    if (!res) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      rw        <= 1'b0;
      rd_d      <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      rw        <= rw_n;
      rd_d      <= reg_rd;
      sda_oe    <= sda_oe_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      reg_we    <= we_n;
      reg_rd    <= rd_n;
      busy      <= busy_n;
    end
  end

  // Next-state and output logic; bus conditions outrank SCL edges
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shreg_n  = shreg;
    rw_n     = rw;
    sda_oe_n = sda_oe;
    addr_n   = reg_addr;
    wdata_n  = reg_wdata;
    we_n     = 1'b0;
    rd_n     = 1'b0;
    busy_n   = busy;

    // Read data arrives the cycle after reg_rd; the next scl_fall is far later
    if (rd_d) shreg_n = reg_rdata;
    // Pointer advances the cycle after a write strobe, so the strobe sees the old value
    if (reg_we) addr_n = reg_addr + 8'd1;

    if (start_ev) begin
      state_n  = ADDR;
      cnt_n    = '0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (stop_ev) begin
      state_n  = IDLE;
      cnt_n    = '0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        IDLE: sda_oe_n = 1'b0;

        ADDR: begin
          if (scl_rise && cnt < 4'd8) begin
            shreg_n = rx_byte;
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                busy_n = 1'b1;
                rw_n   = rx_byte[0];
              end else begin
                state_n = IDLE;
              end
            end
          end else if (scl_fall && cnt == 4'd8) begin
            sda_oe_n = 1'b1;
            state_n  = ADDR_ACK;
          end
        end

        ADDR_ACK: begin
          if (rw) begin
            if (scl_rise) rd_n = 1'b1;
            if (scl_fall) begin
              sda_oe_n = ~shreg[7];
              state_n  = RDATA;
              cnt_n    = '0;
            end
          end else if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = PTR;
            cnt_n    = '0;
          end
        end

        PTR: begin
          if (scl_rise && cnt < 4'd8) begin
            shreg_n = rx_byte;
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd7) addr_n = rx_byte;
          end else if (scl_fall && cnt == 4'd8) begin
            sda_oe_n = 1'b1;
            state_n  = PTR_ACK;
          end
        end

        PTR_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = WDATA;
            cnt_n    = '0;
          end
        end

        WDATA: begin
          if (scl_rise && cnt < 4'd8) begin
            shreg_n = rx_byte;
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              wdata_n = rx_byte;
              we_n    = 1'b1;
            end
          end else if (scl_fall && cnt == 4'd8) begin
            sda_oe_n = 1'b1;
            state_n  = WDATA_ACK;
          end
        end

        WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = WDATA;
            cnt_n    = '0;
          end
        end

        // Bit 7 was put on the bus on entry; each fall here presents the next bit
        RDATA: begin
          if (scl_fall) begin
            if (cnt == 4'd7) begin
              sda_oe_n = 1'b0;
              state_n  = RD_MACK;
              cnt_n    = '0;
            end else begin
              shreg_n  = {shreg[6:0], 1'b0};
              sda_oe_n = ~shreg[6];
              cnt_n    = cnt + 4'd1;
            end
          end
        end

        // cnt=8 marks "master ACKed, next byte requested, wait for scl_fall"
        RD_MACK: begin
          if (scl_rise && cnt == 4'd0) begin
            addr_n = reg_addr + 8'd1;
            if (!sda_f) begin
              rd_n  = 1'b1;
              cnt_n = 4'd8;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end else if (scl_fall && cnt == 4'd8) begin
            sda_oe_n = ~shreg[7];
            state_n  = RDATA;
            cnt_n    = '0;
          end
        end

        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
          busy_n   = 1'b0;
        end
      endcase
    end
  end

endmodule
